// File: rtl/exp_taylor_pkg.sv
// ---------------------------------------------------------------------------
// exp_taylor_pkg
// Shared widths and constants for the pipelined e^x Taylor unit.
//   Input  : unsigned Q1.11 (IN_W bits)
//   Output : unsigned Q3.17 (OUT_W bits)
//   R4..R1 : round(2^17 / k), so that multiplying by R_k and shifting
//            right by FRAC_OUT divides a Q.17 value by k.
// ---------------------------------------------------------------------------
package exp_taylor_pkg;

    localparam int IN_W     = 12;
    localparam int OUT_W    = 20;
    localparam int FRAC_IN  = 11;
    localparam int FRAC_OUT = 17;

    // Intermediate widths: X*a, b = (X*a) >> 11, b*R
    localparam int PROD_W = IN_W + OUT_W;      // 32
    localparam int B_W    = PROD_W - FRAC_IN;  // 21
    localparam int R_W    = 18;
    localparam int BR_W   = B_W + R_W;         // 39

    localparam logic [OUT_W-1:0] F = 20'd131072;  // 1.0 in Q.17

    localparam logic [R_W-1:0] R4 = 18'd32768;
    localparam logic [R_W-1:0] R3 = 18'd43691;
    localparam logic [R_W-1:0] R2 = 18'd65536;
    localparam logic [R_W-1:0] R1 = 18'd131072;

    // Input edge to output-valid edge distance, in clocks.
    localparam int LATENCY = 4;

endpackage

// File: rtl/exp_taylor_stage.sv
// ---------------------------------------------------------------------------
// exp_taylor_stage
// One Horner step: a_out = F + floor(floor(X * a_in / 2^11) * R / 2^17).
// The operand X travels alongside so the next stage sees the same sample.
//
// Ports
//   clk, rst_n   clock, async active-low reset
//   x_i          operand X for this sample (Q1.11)
//   a_i          previous Horner term a_(k+1) (Q.17)
//   valid_i      x_i / a_i carry a live sample
//   x_o          registered X
//   a_o          registered a_k (Q.17)
//   valid_o      registered valid
//
// Flow control is valid-only: a sample is live in a cycle exactly when its
// valid bit is 1; there is no ready/backpressure, so valid advances every
// clock and data registers load only when the accompanying valid is 1.
// ---------------------------------------------------------------------------
module exp_taylor_stage
    import exp_taylor_pkg::*;
#(
    parameter logic [R_W-1:0] R = R1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  x_i,
    input  logic [OUT_W-1:0] a_i,
    input  logic             valid_i,
    output logic [IN_W-1:0]  x_o,
    output logic [OUT_W-1:0] a_o,
    output logic             valid_o
);

    logic [PROD_W-1:0] xa;
    logic [B_W-1:0]    b;
    logic [BR_W-1:0]   br;
    logic [OUT_W-1:0]  c;
    logic              unused_bits;

    logic [IN_W-1:0]  x_q, x_d;
    logic [OUT_W-1:0] a_q, a_d;
    logic             v_q, v_d;

    // x * a in Q.28, truncated back to Q.17
    assign xa = PROD_W'(x_i) * PROD_W'(a_i);
    assign b  = xa[FRAC_IN +: B_W];

    // Divide by k via reciprocal multiply; the quotient always fits OUT_W
    // because the final result stays below 2^20 for every X < 2.
    assign br = BR_W'(b) * BR_W'(R);
    assign c  = br[FRAC_OUT +: OUT_W];

    // Truncated fractional bits and provably-zero top bits.
    assign unused_bits = ^{xa[FRAC_IN-1:0], br[FRAC_OUT-1:0],
                           br[BR_W-1:FRAC_OUT+OUT_W]};

    always_comb begin
        x_d = x_q;
        a_d = a_q;
        v_d = valid_i;
        if (valid_i) begin
            x_d = x_i;
            a_d = F + c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            a_q <= '0;
            v_q <= 1'b0;
        end else begin
            x_q <= x_d;
            a_q <= a_d;
            v_q <= v_d;
        end
    end

    assign x_o     = x_q;
    assign a_o     = a_q;
    assign valid_o = v_q;

endmodule

// File: rtl/exp_taylor_pp.sv
// ---------------------------------------------------------------------------
// exp_taylor_pp
// Fully pipelined e^x for x in [0,2), 4th-order Taylor in Horner form:
//   1 + x(1 + x/2(1 + x/3(1 + x/4)))
// Input rank plus four Horner stages (k = 4, 3, 2, 1); 4-cycle latency,
// one sample per clock, no stalls.
//
// Ports
//   clk          clock, rising edge
//   rst_n        async active-low reset; clears every rank
//   iData        x, unsigned Q1.11
//   iDataValid   iData is live this cycle
//   oData        e^x, unsigned Q3.17; holds last result while invalid
//   oDataValid   oData is live this cycle (one pulse per input)
//
// Flow control is valid-only: valid shifts through all five ranks every
// clock; each data rank loads only when its accompanying valid is 1.
// ---------------------------------------------------------------------------
module exp_taylor_pp
    import exp_taylor_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  iData,
    input  logic             iDataValid,
    output logic [OUT_W-1:0] oData,
    output logic             oDataValid
);

    logic [IN_W-1:0] x_q, x_d;
    logic            v_q, v_d;

    logic [IN_W-1:0]  x4, x3, x2, x1;
    logic [OUT_W-1:0] a4, a3, a2, a1;
    logic             v4, v3, v2, v1;
    logic             unused_x;

    always_comb begin
        x_d = iDataValid ? iData : x_q;
        v_d = iDataValid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            v_q <= 1'b0;
        end else begin
            x_q <= x_d;
            v_q <= v_d;
        end
    end

    // Innermost term starts from a5 = 1.0.
    exp_taylor_stage #(.R(R4)) u_stage4 (
        .clk(clk), .rst_n(rst_n),
        .x_i(x_q), .a_i(F),  .valid_i(v_q),
        .x_o(x4),  .a_o(a4), .valid_o(v4)
    );

    exp_taylor_stage #(.R(R3)) u_stage3 (
        .clk(clk), .rst_n(rst_n),
        .x_i(x4), .a_i(a4), .valid_i(v4),
        .x_o(x3), .a_o(a3), .valid_o(v3)
    );

    exp_taylor_stage #(.R(R2)) u_stage2 (
        .clk(clk), .rst_n(rst_n),
        .x_i(x3), .a_i(a3), .valid_i(v3),
        .x_o(x2), .a_o(a2), .valid_o(v2)
    );

    exp_taylor_stage #(.R(R1)) u_stage1 (
        .clk(clk), .rst_n(rst_n),
        .x_i(x2), .a_i(a2), .valid_i(v2),
        .x_o(x1), .a_o(a1), .valid_o(v1)
    );

    // The last stage's X copy has no consumer.
    assign unused_x = ^x1;

    assign oData      = a1;
    assign oDataValid = v1;

endmodule

// File: tb/tb_exp_taylor_pp.sv
module tb_exp_taylor_pp;

  logic        clk;
  logic        rst_n;
  logic [11:0] iData;
  logic        iDataValid;
  logic [19:0] oData;
  logic        oDataValid;

  exp_taylor_pp dut (
    .clk(clk),
    .rst_n(rst_n),
    .iData(iData),
    .iDataValid(iDataValid),
    .oData(oData),
    .oDataValid(oDataValid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;

  logic [19:0] exp_q[$];
  int          due_q[$];
  logic [19:0] last_exp = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: iterate the Horner recurrence with plain integers.
  function automatic logic [19:0] model(input int unsigned x);
    longint a, b, r;
    a = 131072;
    for (int k = 4; k >= 1; k--) begin
      r = (131072 + k / 2) / k;
      b = (longint'(x) * a) / 2048;
      a = 131072 + (b * r) / 131072;
    end
    return 20'(a);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [11:0] x, input logic [19:0] e);
    @(negedge clk);
    iDataValid = v;
    iData      = x;
    if (v) begin
      exp_q.push_back(e);
      // sampled at the next edge (cyc+1), visible after 4 more edges
      due_q.push_back(cyc + 5);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 12'($urandom_range(0, 4095)), '0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (oDataValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          logic [19:0] e;
          int d;
          e = exp_q.pop_front();
          d = due_q.pop_front();
          check("odata", oData, e);
          check("latency", cyc, d);
          last_exp = e;
        end
      end else begin
        check("hold", oData, last_exp);
      end
    end
  end

  // ---------------- table vectors ----------------
  typedef struct {
    logic [11:0] x;
    logic [19:0] e;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{x: 12'd384,  e: 20'd158102};
    tbl[1] = '{x: 12'd736,  e: 20'd187744};
    tbl[2] = '{x: 12'd0,    e: 20'd131072};
    tbl[3] = '{x: 12'd4095, e: model(4095)};
    tbl[4] = '{x: 12'd2048, e: model(2048)};

    rst_n      = 1'b0;
    iData      = '0;
    iDataValid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_odata", oData, 0);
    check("reset_valid", oDataValid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Isolated samples with gaps; hold checked by the monitor in between.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, tbl[i].x, tbl[i].e);
      idle(6);
    end

    // Back-to-back stream.
    drive(1'b1, 12'd384, 20'd158102);
    drive(1'b1, 12'd736, 20'd187744);
    drive(1'b1, 12'd0,   20'd131072);
    idle(3);
    // After the third input's edge plus 3 more, exactly the first result is out.
    check("b2b_first_valid", oDataValid, 1);
    check("b2b_first_data", oData, 158102);
    idle(6);

    // Reset while two samples are in flight.
    drive(1'b1, 12'd1000, model(1000));
    drive(1'b1, 12'd1500, model(1500));
    drive(1'b0, 12'd0, '0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    due_q.delete();
    last_exp = '0;
    #1;
    check("midreset_odata", oData, 0);
    check("midreset_valid", oDataValid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    check("post_reset_odata", oData, 0);

    // Random traffic.
    for (int i = 0; i < 1000; i++) begin
      logic [11:0] x;
      logic v;
      v = 1'($urandom_range(0, 1));
      x = 12'($urandom_range(0, 4095));
      drive(v, x, model(x));
    end
    idle(1);

    // Drain with a bound.
    begin
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 20) begin
        idle(1);
        t++;
      end
      check("drain_empty", exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
